pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (legal range 1 to 256).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width in bits (legal range 1 to 32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a payload this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  downstream payload valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port flush  input  1  discard all held payloads.
REQ-012 SHALL have port occupancy  output  2  number of held entries (0 to 2).
REQ-013 SHALL have port stall_cnt  output  CNT_W  back-pressure cycle count (see Configuration).

Function
REQ-014 SHALL hold at most two entries: a main register driving out_data and a skid register.
REQ-015 SHALL have three states: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
REQ-016 SHALL define push as in_valid and in_ready, and pop as out_valid and out_ready, both sampled on the same edge.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, registered, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = 1 exactly in ONE and FULL.
REQ-019 SHALL implement these transitions. EMPTY+push goes to ONE with data in main, one-cycle latency. ONE+push without pop goes to FULL with data in skid. ONE+pop without push goes to EMPTY. ONE+push+pop stays ONE with main loaded from in_data. FULL+pop goes to ONE with main loaded from skid. In all other cases the state is held.
REQ-020 SHALL deliver payloads strictly in acceptance order, never duplicating or dropping any accepted payload (except on flush or reset).
REQ-021 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL hold the last out_data value when out_valid = 0.
REQ-023 SHALL, on flush = 1, go to EMPTY at the next edge; a push in the same cycle is discarded; a pop in the same cycle completes normally downstream.
REQ-024 SHALL give flush priority over push and pop, and give rst priority over flush.
REQ-025 SHALL, when WIDTH = 1, behave identically to any other width.

Reset
REQ-026 SHALL, at rst = 1, force the state to EMPTY at the next edge.
REQ-027 SHALL, after that edge, have out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0 and stall_cnt = 0.
REQ-028 SHALL discard in-flight payloads on a reset mid-operation; in_valid and out_ready are ignored while rst = 1.

Configuration
REQ-029 SHALL compile the stall counter only when PIPE_SKID_STALL_CNT_EN is defined.
REQ-030 SHALL, with the macro defined, increment stall_cnt each cycle with out_valid = 1 and out_ready = 0, saturate at 2^CNT_W - 1, clear only on rst, and leave it unaffected by flush.
REQ-031 SHALL, without the macro, keep the stall_cnt port present but tied to 0, with no counter logic.

Verification
REQ-032 SHALL pass this scenario: after reset, push 0xA5A5A5A5 with out_ready = 1 -> out_valid = 1 and out_data = 0xA5A5A5A5 one cycle later, occupancy = 1.
REQ-033 SHALL pass this scenario: out_ready = 0, push 0x11 then 0x22 -> occupancy = 2 and in_ready = 0; a third push of 0x33 is not accepted; raising out_ready -> outputs 0x11 then 0x22, and 0x33 is accepted once in_ready = 1.
REQ-034 SHALL pass this scenario: continuous in_valid and out_ready with data 1..100 -> 100 outputs in order 1..100 at one per cycle, occupancy never exceeds 1.
REQ-035 SHALL pass this scenario: in FULL, assert flush with in_valid = 1 and data 0x77 -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, and 0x77 is never output.
REQ-036 SHALL pass this scenario: in FULL, assert rst for one cycle -> next cycle out_valid = 0, out_data = 0, stall_cnt = 0.
REQ-037 SHALL pass this scenario: with the macro defined and CNT_W = 3, hold out_valid = 1 and out_ready = 0 for 10 cycles -> stall_cnt = 7; without the macro, stall_cnt = 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: a main register drives out_data and a skid register absorbs one extra beat.
// Optional back-pressure counter is compiled in with `define PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  // Handshake outputs decode only the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload registers keep their contents so out_data holds its last value.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of cycles with data waiting on a stalled consumer; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a queue scoreboard
// that tracks every accepted payload and compares it when the DUT hands it downstream.
module tb_pipe_skid_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             flush = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb[$];
  logic             hold = 1'b0;
  logic [WIDTH-1:0] held;

  pipe_skid_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so at negedge they show what the next edge will sample.
  always @(negedge clk) begin
    int n;
    logic [WIDTH-1:0] exp;
    if (hold) begin
      checks++;
      if (out_data !== held) begin
        errors++;
        $display("FAIL hold_stable got %h exp %h", out_data, held);
      end
    end
    hold = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      n = sb.size();
      checks++;
      if (occupancy !== 2'(n) || out_valid !== (n != 0) || in_ready !== (n < 2)) begin
        errors++;
        $display("FAIL state_vs_model occ %0d valid %b ready %b exp occ %0d", occupancy, out_valid, in_ready, n);
      end
      if (out_valid && !out_ready) begin
        hold = 1'b1;
        held = out_data;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (n == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h exp none", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL output_order got %h exp %h", out_data, exp);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state valid %b data %h ready %b occ %0d stall %0d exp 0 0 1 0 0",
               out_valid, out_data, in_ready, occupancy, stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5A5A5;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL single_push valid %b data %h occ %0d exp 1 a5a5a5a5 1", out_valid, out_data, occupancy);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL bp_full occ %0d ready %b data %h exp 2 0 11", occupancy, in_ready, out_data);
    end
    in_data = 32'h33;
    step();
    checks++;
    if (occupancy !== 2'd2 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL bp_third_refused occ %0d data %h exp 2 11", occupancy, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 32'h22 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_drain1 data %h ready %b occ %0d exp 22 1 1", out_data, in_ready, occupancy);
    end
    step();
    checks++;
    if (out_data !== 32'h33 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_accept33 data %h occ %0d exp 33 1", out_data, occupancy);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h33) begin
      errors++;
      $display("FAIL empty_holds_data valid %b data %h exp 0 33", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i) || occupancy > 2'd1) begin
        errors++;
        $display("FAIL b2b_%0d valid %b data %0d occ %0d exp 1 %0d <=1", i, out_valid, out_data, occupancy, i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL b2b_drain occ %0d exp 0", occupancy);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    checks++;
`ifdef PIPE_SKID_STALL_CNT_EN
    if (stall_cnt !== 3'd7) begin
      errors++;
      $display("FAIL stall_saturate got %0d exp 7", stall_cnt);
    end
`else
    if (stall_cnt !== 3'd0) begin
      errors++;
      $display("FAIL stall_tied_off got %0d exp 0", stall_cnt);
    end
`endif
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    step();
    in_data = 32'h66;
    step();
    flush = 1'b1; in_data = 32'h77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full occ %0d valid %b ready %b exp 0 0 1", occupancy, out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_77 valid %b data %h exp valid 0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_rst_full();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
    step();
    in_data = 32'hA2;
    step();
    repeat (3) step();
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || stall_cnt !== '0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rst_full valid %b data %h stall %0d occ %0d exp 0 0 0 0", out_valid, out_data, stall_cnt, occupancy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = $urandom;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain left %0d valid %b exp 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_stall();
    test_flush();
    test_rst_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
